// File: rtl/dc_vlc_slice_sequencer_pkg.sv
// Shared defaults, widths and FSM encoding for the DC VLC slice sequencer.
// Also holds the blocks-per-slice sanitiser used at slice start.
package dc_vlc_slice_sequencer_pkg;

    localparam int ENC_LATENCY_DEF  = 6;
    localparam int FIFO_DEPTH_DEF   = 32;
    localparam int RESET_CYCLES_DEF = 2;
    localparam int COEFF_W          = 32;
    localparam int BPS_W            = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DRAIN = 2'd3
    } seq_state_e;

    // Out-of-range slice sizes (0 or above the buffer depth) mean a full buffer.
    function automatic logic [BPS_W:0] eff_blocks(input logic [BPS_W-1:0] bps,
                                                   input int depth);
        if (bps == '0 || int'(bps) > depth)
            return (BPS_W+1)'(depth);
        return {1'b0, bps};
    endfunction

endpackage

// File: rtl/dc_vlc_slice_sequencer_coeff_fifo.sv
// dc_coeff_fifo: single-clock coefficient buffer with occupancy count.
// Read data is first-word fall-through (combinational from the read pointer).
module dc_coeff_fifo #(
    parameter int DEPTH = 32,
    parameter int W     = 32
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         push,
    input  logic [W-1:0]                 wdata,
    input  logic                         pop,
    output logic [W-1:0]                 rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full
);

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             empty, do_push, do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Explicit wrap so non-power-of-two depths also work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/dc_vlc_slice_sequencer.sv
// Buffers DC coefficients, feeds one slice at a time gap-free into an external
// fixed-latency DC entropy encoder, and registers the returning codewords.
module dc_vlc_slice_sequencer
    import dc_vlc_slice_sequencer_pkg::*;
#(
    parameter int ENC_LATENCY  = ENC_LATENCY_DEF,
    parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
    parameter int RESET_CYCLES = RESET_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [BPS_W-1:0]   blocks_per_slice,
    input  logic               in_valid,
    input  logic [COEFF_W-1:0] in_coeff,
    output logic               in_ready,
    output logic               enc_reset_n,
    output logic [COEFF_W-1:0] enc_dc_coeff,
    input  logic [31:0]        enc_sum,
    input  logic [31:0]        enc_length,
    output logic               out_valid,
    output logic [31:0]        out_codeword,
    output logic [31:0]        out_length,
    output logic               out_last,
    output logic [31:0]        slice_bits,
    output logic               slice_done,
    output logic               busy
);

    localparam int CNT_W = $clog2(FIFO_DEPTH+1);
    localparam int N_W   = BPS_W + 1;
    localparam int RC_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES+1) : 1;

    seq_state_e         state, state_nx;
    logic [N_W-1:0]     n_lat, eff_n, issue_cnt;
    logic [RC_W-1:0]    prime_cnt;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full;
    logic [COEFF_W-1:0] fifo_rdata;
    logic               ready_en, start, pop, pop_last;
    logic [ENC_LATENCY:0] vld_pipe, last_pipe;

    assign eff_n    = eff_blocks(blocks_per_slice, FIFO_DEPTH);
    assign in_ready = ready_en && !fifo_full;
    assign busy     = (state != ST_IDLE);
    assign pop_last = pop && (issue_cnt == n_lat - N_W'(1));

    dc_coeff_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (COEFF_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (in_valid && in_ready),
        .wdata   (in_coeff),
        .pop     (pop),
        .rdata   (fifo_rdata),
        .count   (fifo_count),
        .full    (fifo_full)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        pop      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (N_W'(fifo_count) >= eff_n) begin
                    state_nx = ST_PRIME;
                    start    = 1'b1;
                end
            end
            ST_PRIME: begin
                if (prime_cnt == RC_W'(RESET_CYCLES-1)) state_nx = ST_ISSUE;
            end
            ST_ISSUE: begin
                pop = 1'b1;
                if (issue_cnt == n_lat - N_W'(1)) state_nx = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (out_last) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Issue side: slice size latch, prime/issue counters, encoder drive.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_en     <= 1'b0;
            n_lat        <= '0;
            prime_cnt    <= '0;
            issue_cnt    <= '0;
            enc_reset_n  <= 1'b0;
            enc_dc_coeff <= '0;
        end else begin
            ready_en    <= 1'b1;
            enc_reset_n <= (state_nx != ST_PRIME);
            if (start) n_lat <= eff_n;
            prime_cnt   <= (state == ST_PRIME) ? prime_cnt + RC_W'(1) : '0;
            issue_cnt   <= pop ? issue_cnt + N_W'(1) : '0;
            if (pop) enc_dc_coeff <= fifo_rdata;
        end
    end

    // Tag pipe: stage 0 marks the cycle a coefficient sits on enc_dc_coeff,
    // stage ENC_LATENCY marks the cycle its codeword sits on enc_sum.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
        end else begin
            vld_pipe[0]  <= pop;
            last_pipe[0] <= pop_last;
            vld_pipe[ENC_LATENCY:1]  <= vld_pipe[ENC_LATENCY-1:0];
            last_pipe[ENC_LATENCY:1] <= last_pipe[ENC_LATENCY-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            slice_done   <= 1'b0;
            out_codeword <= '0;
            out_length   <= '0;
            slice_bits   <= '0;
        end else begin
            out_valid  <= vld_pipe[ENC_LATENCY];
            out_last   <= last_pipe[ENC_LATENCY];
            slice_done <= last_pipe[ENC_LATENCY];
            if (vld_pipe[ENC_LATENCY]) begin
                out_codeword <= enc_sum;
                out_length   <= enc_length;
            end
            // Sum lands together with the last codeword so slice_done sees the total.
            if (start)
                slice_bits <= '0;
            else if (vld_pipe[ENC_LATENCY])
                slice_bits <= slice_bits + enc_length;
        end
    end

endmodule

// File: tb/tb_dc_vlc_slice_sequencer.sv
// Directed bench for dc_vlc_slice_sequencer with a stub fixed-latency encoder
// and a queue-based slice model checked every cycle on the falling edge.
module tb_dc_vlc_slice_sequencer;

    localparam int ENC_LAT = 6;
    localparam int RST_CYC = 2;

    logic        clk, reset_n;
    logic [5:0]  bps;
    logic        in_valid, in_ready;
    logic [31:0] in_coeff;
    logic        enc_reset_n;
    logic [31:0] enc_dc_coeff, enc_sum, enc_length;
    logic        out_valid, out_last, slice_done, busy;
    logic [31:0] out_codeword, out_length, slice_bits;

    dc_vlc_slice_sequencer #(
        .ENC_LATENCY  (ENC_LAT),
        .FIFO_DEPTH   (32),
        .RESET_CYCLES (RST_CYC)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .blocks_per_slice (bps),
        .in_valid         (in_valid),
        .in_coeff         (in_coeff),
        .in_ready         (in_ready),
        .enc_reset_n      (enc_reset_n),
        .enc_dc_coeff     (enc_dc_coeff),
        .enc_sum          (enc_sum),
        .enc_length       (enc_length),
        .out_valid        (out_valid),
        .out_codeword     (out_codeword),
        .out_length       (out_length),
        .out_last         (out_last),
        .slice_bits       (slice_bits),
        .slice_done       (slice_done),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stub encoder: fixed latency, codeword/length are simple functions of the coefficient.
    function automatic logic [31:0] f_sum(input logic [31:0] c);
        return c ^ 32'hA5A5_0000;
    endfunction
    function automatic logic [31:0] f_len(input logic [31:0] c);
        return {28'd0, c[3:0]} + 32'd1;
    endfunction

    logic [31:0] enc_pipe [ENC_LAT];
    always @(posedge clk) begin
        enc_pipe[0] <= enc_dc_coeff;
        for (int i = 1; i < ENC_LAT; i++) enc_pipe[i] <= enc_pipe[i-1];
    end
    assign enc_sum    = f_sum(enc_pipe[ENC_LAT-1]);
    assign enc_length = f_len(enc_pipe[ENC_LAT-1]);

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic flag(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // Model state: accepted coefficients in order, and the slice sizes the stimulus expects.
    logic [31:0] acc_q[$];
    int          slice_n_q[$];
    logic [31:0] done_hist[$];
    int          idx = 0, cur_n = 0, low_run = 0, rise_cyc = 0, outstanding = 0, done_cnt = 0;
    int          last_lat = 0, last_low = 0;
    bit          prev_enr = 1'b0, ign = 1'b1, prev_last = 1'b0;
    logic [31:0] run_bits, slice_first_cw, c;

    always @(negedge clk) begin
        if (!reset_n) begin
            acc_q.delete();
            slice_n_q.delete();
            idx = 0; cur_n = 0; low_run = 0; outstanding = 0;
            ign = 1'b1; prev_enr = 1'b0; prev_last = 1'b0;
        end else begin
            if (in_valid && in_ready) acc_q.push_back(in_coeff);

            if (!enc_reset_n) begin
                if (!ign) begin
                    if (prev_enr) chk("prime_before_drain_done", outstanding, 0);
                    chk("bits_cleared_in_prime", slice_bits, 0);
                end
                low_run++;
            end else begin
                if (!prev_enr) begin
                    if (ign) ign = 1'b0;
                    else begin
                        chk("enc_reset_low_cycles", low_run, RST_CYC);
                        last_low = low_run;
                        rise_cyc = cyc;
                        outstanding++;
                    end
                end
                low_run = 0;
            end
            prev_enr = enc_reset_n;

            if (prev_last) chk("idle_after_last", busy, 0);

            if (out_valid) begin
                if (cur_n == 0) begin
                    if (slice_n_q.size() == 0) flag("unexpected_out_valid");
                    else begin
                        cur_n    = slice_n_q.pop_front();
                        idx      = 0;
                        run_bits = 0;
                        last_lat = cyc - rise_cyc;
                        chk("first_out_latency", cyc - rise_cyc, ENC_LAT + 2);
                        slice_first_cw = out_codeword;
                    end
                end
                if (cur_n > 0) begin
                    if (acc_q.size() == 0) flag("out_without_coeff");
                    else begin
                        c = acc_q.pop_front();
                        run_bits = run_bits + f_len(c);
                        chk("codeword", out_codeword, f_sum(c));
                        chk("length", out_length, f_len(c));
                        chk("out_last", out_last, (idx == cur_n - 1));
                        chk("slice_done", slice_done, (idx == cur_n - 1));
                    end
                    if (idx == cur_n - 1) begin
                        chk("slice_bits", slice_bits, run_bits);
                        done_hist.push_back(slice_bits);
                        done_cnt++;
                        outstanding--;
                        cur_n = 0;
                        idx = 0;
                    end else idx++;
                end
            end else begin
                chk("out_last_idle", out_last, 0);
                chk("slice_done_idle", slice_done, 0);
                if (cur_n > 0) flag("gap_in_out_valid");
                cur_n = 0;
                idx = 0;
            end
            prev_last = out_valid && out_last;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic push(input logic [31:0] v);
        int t = 0;
        in_valid = 1'b1;
        in_coeff = v;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) flag("push_timeout");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int t = 0;
        while (done_cnt < target && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (done_cnt < target) flag("slice_done_timeout");
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    int t0, dt, tw;

    initial begin
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_coeff = '0;
        bps      = 6'd4;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_enc_reset_n", enc_reset_n, 0);
        chk("rst_slice_bits", slice_bits, 0);
        chk("rst_enc_dc_coeff", enc_dc_coeff, 0);
        chk("rst_out_codeword", out_codeword, 0);
        step();
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("ready_after_reset", in_ready, 1);
        chk("enc_reset_n_idle", enc_reset_n, 1);
        step();

        // Four back-to-back coefficients: lengths 5+7+4+4.
        bps = 6'd4;
        slice_n_q.push_back(4);
        push(32'd100); push(32'd102); push(32'd99); push(32'd99);
        wait_done(1);
        chk("s1_bits", done_hist[0], 32'd20);
        chk("s1_first_cw", slice_first_cw, 32'hA5A5_0064);
        chk("s1_prime_len", last_low, 2);
        chk("s1_latency", last_lat, 8);

        // Sparse arrivals: nothing may start until the third is buffered.
        bps = 6'd3;
        slice_n_q.push_back(3);
        push(-32'sd5); step(); step();
        chk("sparse_idle_1", busy, 0);
        push(32'd7); step(); step();
        @(negedge clk);
        chk("sparse_idle_2", busy, 0);
        step();
        push(32'd1000);
        wait_done(2);
        chk("s2_bits", done_hist[1], 32'd29);
        chk("s2_first_cw", slice_first_cw, 32'h5A5A_FFFB);

        // Two slices of two, queued together.
        bps = 6'd2;
        slice_n_q.push_back(2);
        slice_n_q.push_back(2);
        push(32'd1); push(32'd2); push(32'd3); push(32'd4);
        wait_done(4);
        chk("s3_bits", done_hist[2], 32'd5);
        chk("s4_bits", done_hist[3], 32'd9);

        // Full buffer, then refill during issue (push and pop every cycle).
        bps = 6'd32;
        slice_n_q.push_back(32);
        for (int i = 0; i < 32; i++) push(32'h1000 + i);
        t0 = cyc;
        @(negedge clk);
        chk("full_in_ready_low", in_ready, 0);
        step();
        slice_n_q.push_back(32);
        for (int i = 0; i < 31; i++) push(32'h2000 + i);
        dt = cyc - t0;
        chk("refill_stream_cycles", dt, 35);
        wait_done(5);
        bps = 6'd0;
        repeat (4) @(negedge clk);
        chk("bps0_waits_for_32", busy, 0);
        chk("count31_ready", in_ready, 1);
        step();
        push(32'h2000 + 31);
        wait_done(6);

        // Reset in the middle of an 8-block slice.
        bps = 6'd8;
        slice_n_q.push_back(8);
        for (int i = 0; i < 8; i++) push(32'h3000 + i);
        tw = 0;
        while (outstanding == 0 && tw < 100) begin
            @(negedge clk);
            tw++;
        end
        if (outstanding == 0) flag("mid_slice_start_timeout");
        step(); step(); step();
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_enc_reset_n", enc_reset_n, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_enc_dc_coeff", enc_dc_coeff, 0);
        chk("midrst_slice_bits", slice_bits, 0);
        chk("midrst_out_length", out_length, 0);
        #10 reset_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("post_rst_no_output", out_valid, 0);
        bps = 6'd1;
        repeat (5) @(negedge clk);
        chk("post_rst_fifo_empty", busy, 0);
        step();
        slice_n_q.push_back(1);
        push(32'h4242);
        wait_done(7);
        chk("post_rst_bits", done_hist[6], 32'd3);

        repeat (5) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
